// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared request codes, FSM encoding and defaults for dram_responder
//
// Purpose: common definitions used by dram_responder and its block RAM.
// Contents:
//   DRAM_REQ_*      request codes carried on D_REQ
//   state_e         responder FSM states
//   DRAM_DATA_W_DEF default block width in bits
package dram_responder_pkg;

  localparam logic [1:0] DRAM_REQ_NONE  = 2'd0;
  localparam logic [1:0] DRAM_REQ_WRITE = 2'd1;
  localparam logic [1:0] DRAM_REQ_READ  = 2'd2;
  localparam logic [1:0] DRAM_REQ_RSVD  = 2'd3;

  localparam int DRAM_DATA_W_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RLAT  = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/dram_responder_ram.sv
// rtl/dram_responder_ram.sv - simple dual-port block RAM with 1-cycle registered read
//
// Module dramresp_ram: DATA_W x 2^ADDR_W storage, no reset (contents survive reset).
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write block index
//   wdata_i  write data
//   raddr_i  read block index, sampled every cycle
//   rdata_o  read data, valid one cycle after raddr_i
module dramresp_ram #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - block-RAM backed responder for the user-side DRAM request interface
//
// Accepts write/read bursts of DATA_W-bit blocks on D_REQ and serves them from
// on-chip RAM with a fixed read latency of RD_LAT cycles.
// Optional feature macro: DRAMRESP_STALL_EN inserts one idle transfer cycle
// after every STALL_PERIOD blocks.
// Ports:
//   CLK, RST_X      clock, asynchronous active-low reset
//   D_REQ           0 none, 1 write, 2 read, 3 reserved
//   D_INITADR       start address in 8-byte units
//   D_ELEM          burst length in blocks
//   D_BUSY          request in progress
//   D_DIN, D_W      write data, consumed on each cycle D_W is high
//   D_DOUT, D_DOUTEN read data and its valid
//   ERR             sticky protocol-violation flag
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int DATA_W       = DRAM_DATA_W_DEF,
  parameter int ADDR_W       = 10,
  parameter int RD_LAT       = 4,
  parameter int STALL_PERIOD = 4
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [1:0]        D_REQ,
  input  logic [31:0]       D_INITADR,
  input  logic [31:0]       D_ELEM,
  output logic              D_BUSY,
  input  logic [DATA_W-1:0] D_DIN,
  output logic              D_W,
  output logic [DATA_W-1:0] D_DOUT,
  output logic              D_DOUTEN,
  output logic              ERR
);

`ifdef DRAMRESP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam int LAT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int CNT_W = $clog2(STALL_PERIOD + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       rem_q, rem_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              dw_q, dw_d;
  logic              douten_q, douten_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;
  logic              ram_we;
  logic              cap;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_adr;

  assign req_idx    = D_INITADR[ADDR_W+2:3];
  assign unused_adr = ^{D_INITADR[31:ADDR_W+3], D_INITADR[2:0]};

  // The RAM is addressed with the next pointer, so its registered output always
  // holds RAM[ptr_q]. A read capture therefore sees the block at ptr_q, and a
  // stall simply re-reads the same block: nothing in flight can be lost.
  dramresp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ptr_q),
    .wdata_i (D_DIN),
    .raddr_i (ptr_d),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    dw_d     = dw_q;
    douten_d = 1'b0;
    dout_d   = dout_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    cap      = 1'b0;

    if (busy_q && (D_REQ != DRAM_REQ_NONE)) err_d = 1'b1;
    if (!busy_q && (D_REQ == DRAM_REQ_RSVD)) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if ((D_REQ == DRAM_REQ_WRITE) || (D_REQ == DRAM_REQ_READ)) begin
          ptr_d  = req_idx;
          rem_d  = D_ELEM;
          busy_d = 1'b1;
          cnt_d  = '0;
          if ((D_REQ == DRAM_REQ_READ) && (D_ELEM != '0)) begin
            state_d = ST_RLAT;
            lat_d   = LAT_W'(RD_LAT - 2);
          end else begin
            // Zero-length requests of either kind park in WRITE for one
            // cycle with D_W low, giving the single-cycle busy pulse.
            state_d = ST_WRITE;
            dw_d    = (D_ELEM != '0);
          end
        end
      end

      ST_WRITE: begin
        if (dw_q) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 32'd1;
          cnt_d  = cnt_q + 1'b1;
        end
        if (rem_d == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          dw_d    = 1'b0;
        end else if (STALL_EN && dw_q && (cnt_d == CNT_W'(STALL_PERIOD))) begin
          dw_d  = 1'b0;
          cnt_d = '0;
        end else begin
          dw_d = 1'b1;
        end
      end

      ST_RLAT: begin
        if (lat_q == '0) cap = 1'b1;
        else             lat_d = lat_q - 1'b1;
      end

      ST_READ: begin
        if (rem_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (STALL_EN && (cnt_q == CNT_W'(STALL_PERIOD))) begin
          cnt_d = '0;
        end else begin
          cap = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (cap) begin
      state_d  = ST_READ;
      douten_d = 1'b1;
      dout_d   = ram_rdata;
      ptr_d    = ptr_q + 1'b1;
      rem_d    = rem_q - 32'd1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      lat_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      dw_q     <= 1'b0;
      douten_q <= 1'b0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      lat_q    <= lat_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      dw_q     <= dw_d;
      douten_q <= douten_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign D_BUSY   = busy_q;
  assign D_W      = dw_q;
  assign D_DOUTEN = douten_q;
  assign D_DOUT   = dout_q;
  assign ERR      = err_q;

endmodule
